// File: rtl/alu_issue.sv
// alu_issue: decode/issue stage in front of the ALU. Splits a 32-bit
// instruction into opcode/cc/rd/ra/rb/immediate, reads operands from the
// register file, stalls on scoreboard hazards and issues a registered bundle.
// Latency: one cycle from accept to ex_valid; full throughput without hazards.
// Backpressure: in_ready drops on a source hazard or when a held bundle is
// not being taken by execute (ex_valid && !ex_ready).
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   in_valid/in_ready/in_instr   fetch handshake and instruction word
//   rf_ra_addr/rf_rb_addr    combinational register-file read addresses
//   rf_ra_data/rf_rb_data    combinational register-file read data
//   ex_valid/ex_ready        issue handshake; ex_opcode/ex_cc/ex_data_a/
//                            ex_data_b/ex_rd/ex_wen form the issued bundle
//   wb_valid/wb_rd           writeback completion, clears a pending bit
//   illegal                  one-cycle pulse when an undefined opcode is dropped
module alu_issue #(
  parameter int NUM_REGS = 32,
  localparam int WIDTH   = 32,
  localparam int BITSIZE = $clog2(NUM_REGS)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_instr,
  output logic [BITSIZE-1:0] rf_ra_addr,
  output logic [BITSIZE-1:0] rf_rb_addr,
  input  logic [WIDTH-1:0]   rf_ra_data,
  input  logic [WIDTH-1:0]   rf_rb_data,
  output logic               ex_valid,
  input  logic               ex_ready,
  output logic [4:0]         ex_opcode,
  output logic [2:0]         ex_cc,
  output logic [WIDTH-1:0]   ex_data_a,
  output logic [WIDTH-1:0]   ex_data_b,
  output logic [BITSIZE-1:0] ex_rd,
  output logic               ex_wen,
  input  logic               wb_valid,
  input  logic [BITSIZE-1:0] wb_rd,
  output logic               illegal
);

  // Opcode map is dense: ADD=0 SUB=1 MPY=2 AND=3 OR=4 XOR=5 SHL=6 SRL=7
  // SRA=8 CMP=9 MOV=10; everything above MOV is undefined.
  localparam logic [4:0] OP_MOV = 5'd10;

  // Decoded fields of the instruction currently offered by fetch
  logic [4:0]         op;
  logic [BITSIZE-1:0] rd, ra, rb;
  logic               use_imm;
  logic               is_def;
  logic               reads_rb;
  logic               hazard;
  logic               accept;
  logic               load;
  logic               wen;
  logic [2:0]         cc;
  logic [WIDTH-1:0]   a_val;
  logic [WIDTH-1:0]   b_val;

  // State
  logic                ex_valid_q, ex_valid_d;
  logic [4:0]          ex_opcode_q, ex_opcode_d;
  logic [2:0]          ex_cc_q, ex_cc_d;
  logic [WIDTH-1:0]    ex_data_a_q, ex_data_a_d;
  logic [WIDTH-1:0]    ex_data_b_q, ex_data_b_d;
  logic [BITSIZE-1:0]  ex_rd_q, ex_rd_d;
  logic                ex_wen_q, ex_wen_d;
  logic [NUM_REGS-1:0] pend_q, pend_d;
  logic                illegal_q, illegal_d;

  assign op      = in_instr[31:27];
  assign rd      = in_instr[22 +: BITSIZE];
  assign ra      = in_instr[17 +: BITSIZE];
  assign use_imm = in_instr[16];
  assign rb      = in_instr[11 +: BITSIZE];

  assign rf_ra_addr = ra;
  assign rf_rb_addr = rb;

  assign is_def   = (op <= OP_MOV);
  // Only the register form of a two-operand op actually reads rb
  assign reads_rb = is_def && (op != OP_MOV) && !use_imm;

  // pend_q[0] is never set, so r0 sources can never stall.
  // Same-cycle writeback does not lift the stall: only pend_q is consulted.
  assign hazard = is_def && (pend_q[ra] || (reads_rb && pend_q[rb]));

  assign in_ready = !hazard && (!ex_valid_q || ex_ready);
  assign accept   = in_valid && in_ready;
  assign load     = accept && is_def;
  assign wen      = (rd != '0);

  assign cc    = use_imm ? 3'b000 : in_instr[10:8];
  assign a_val = (ra == '0) ? '0 : rf_ra_data;

  always_comb begin
    b_val = '0;
    if (op == OP_MOV)
      b_val = '0;
    else if (use_imm)
      b_val = {{(WIDTH-16){in_instr[15]}}, in_instr[15:0]};
    else if (rb != '0)
      b_val = rf_rb_data;
  end

  always_comb begin
    ex_valid_d  = ex_valid_q;
    ex_opcode_d = ex_opcode_q;
    ex_cc_d     = ex_cc_q;
    ex_data_a_d = ex_data_a_q;
    ex_data_b_d = ex_data_b_q;
    ex_rd_d     = ex_rd_q;
    ex_wen_d    = ex_wen_q;
    pend_d      = pend_q;
    illegal_d   = accept && !is_def;

    if (load) begin
      ex_valid_d  = 1'b1;
      ex_opcode_d = op;
      ex_cc_d     = cc;
      ex_data_a_d = a_val;
      ex_data_b_d = b_val;
      ex_rd_d     = rd;
      ex_wen_d    = wen;
    end else if (ex_ready) begin
      ex_valid_d  = 1'b0;
    end

    // Clear first so that a same-cycle set of the same register wins
    if (wb_valid)
      pend_d[wb_rd] = 1'b0;
    if (load && wen)
      pend_d[rd] = 1'b1;
    pend_d[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_valid_q  <= 1'b0;
      ex_opcode_q <= '0;
      ex_cc_q     <= '0;
      ex_data_a_q <= '0;
      ex_data_b_q <= '0;
      ex_rd_q     <= '0;
      ex_wen_q    <= 1'b0;
      pend_q      <= '0;
      illegal_q   <= 1'b0;
    end else begin
      ex_valid_q  <= ex_valid_d;
      ex_opcode_q <= ex_opcode_d;
      ex_cc_q     <= ex_cc_d;
      ex_data_a_q <= ex_data_a_d;
      ex_data_b_q <= ex_data_b_d;
      ex_rd_q     <= ex_rd_d;
      ex_wen_q    <= ex_wen_d;
      pend_q      <= pend_d;
      illegal_q   <= illegal_d;
    end
  end

  assign ex_valid  = ex_valid_q;
  assign ex_opcode = ex_opcode_q;
  assign ex_cc     = ex_cc_q;
  assign ex_data_a = ex_data_a_q;
  assign ex_data_b = ex_data_b_q;
  assign ex_rd     = ex_rd_q;
  assign ex_wen    = ex_wen_q;
  assign illegal   = illegal_q;

endmodule

// File: tb/tb_alu_issue.sv
// Bench for alu_issue: directed scenarios with literal expectations, then
// randomized traffic checked every cycle against a behavioural model.
module tb_alu_issue;

  localparam logic [4:0] ADD = 5'd0, SUB = 5'd1, XOR = 5'd5, SRA = 5'd8, MOV = 5'd10;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic [4:0]  rf_ra_addr, rf_rb_addr;
  logic [31:0] rf_ra_data, rf_rb_data;
  logic        ex_valid;
  logic        ex_ready;
  logic [4:0]  ex_opcode;
  logic [2:0]  ex_cc;
  logic [31:0] ex_data_a, ex_data_b;
  logic [4:0]  ex_rd;
  logic        ex_wen;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_dat;
  logic        illegal;

  logic [31:0] rf [32];

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  assign rf_ra_data = rf[rf_ra_addr];
  assign rf_rb_data = rf[rf_rb_addr];

  alu_issue #(.NUM_REGS(32)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
    .rf_ra_addr(rf_ra_addr), .rf_rb_addr(rf_rb_addr),
    .rf_ra_data(rf_ra_data), .rf_rb_data(rf_rb_data),
    .ex_valid(ex_valid), .ex_ready(ex_ready),
    .ex_opcode(ex_opcode), .ex_cc(ex_cc),
    .ex_data_a(ex_data_a), .ex_data_b(ex_data_b),
    .ex_rd(ex_rd), .ex_wen(ex_wen),
    .wb_valid(wb_valid), .wb_rd(wb_rd),
    .illegal(illegal)
  );

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit          pend [32];
  logic        m_vld, m_ill, m_wen;
  logic [4:0]  m_op, m_rd;
  logic [2:0]  m_cc;
  logic [31:0] m_a, m_b;
  logic        hs_in;
  logic [4:0]  wbq [$];

  task automatic model_reset();
    foreach (pend[i]) pend[i] = 1'b0;
    m_vld = 0; m_ill = 0; m_wen = 0; m_op = 0; m_rd = 0; m_cc = 0; m_a = 0; m_b = 0;
  endtask

  initial model_reset();

  always @(negedge clk) begin
    if (rst) begin
      model_reset();
      hs_in = 1'b0;
      check("rst_ex_valid", {63'd0, ex_valid}, 64'd0);
      check("rst_illegal", {63'd0, illegal}, 64'd0);
      check("rst_bundle", {ex_opcode, ex_cc, ex_data_a, ex_data_b, ex_rd, ex_wen}, 64'd0);
    end else begin
      logic [4:0]  op, rd, ra, rb;
      logic        imm, def, haz, exp_rdy, acc;
      logic [31:0] va, vb;
      op  = in_instr[31:27];
      rd  = in_instr[26:22];
      ra  = in_instr[21:17];
      imm = in_instr[16];
      rb  = in_instr[15:11];
      def = (op <= MOV);
      haz = def && (pend[ra] || (op != MOV && !imm && pend[rb]));
      exp_rdy = !haz && (!m_vld || ex_ready);
      va = (ra == 0) ? 32'd0 : rf[ra];
      if (imm) vb = {{16{in_instr[15]}}, in_instr[15:0]};
      else     vb = (rb == 0) ? 32'd0 : rf[rb];

      check("in_ready", {63'd0, in_ready}, {63'd0, exp_rdy});
      check("rf_ra_addr", {59'd0, rf_ra_addr}, {59'd0, ra});
      check("rf_rb_addr", {59'd0, rf_rb_addr}, {59'd0, rb});
      check("ex_valid", {63'd0, ex_valid}, {63'd0, m_vld});
      check("illegal", {63'd0, illegal}, {63'd0, m_ill});
      check("ex_opcode", {59'd0, ex_opcode}, {59'd0, m_op});
      check("ex_cc", {61'd0, ex_cc}, {61'd0, m_cc});
      check("ex_data_a", {32'd0, ex_data_a}, {32'd0, m_a});
      if (m_op != MOV) check("ex_data_b", {32'd0, ex_data_b}, {32'd0, m_b});
      check("ex_rd", {59'd0, ex_rd}, {59'd0, m_rd});
      check("ex_wen", {63'd0, ex_wen}, {63'd0, m_wen});

      hs_in = in_valid && in_ready;

      // advance the model across the coming rising edge
      acc = in_valid && exp_rdy;
      if (m_vld && ex_ready && m_wen) wbq.push_back(m_rd);
      if (acc && def) begin
        m_vld = 1; m_op = op; m_rd = rd; m_wen = (rd != 0);
        m_cc = imm ? 3'd0 : in_instr[10:8];
        m_a = va; m_b = vb;
      end else if (ex_ready) begin
        m_vld = 0;
      end
      m_ill = acc && !def;
      if (wb_valid) pend[wb_rd] = 1'b0;
      if (acc && def && rd != 0) pend[rd] = 1'b1;
    end
  end

  // ---------------- stimulus ----------------
  function automatic logic [31:0] mk(input logic [4:0] op, input logic [4:0] rd, input logic [4:0] ra,
                                     input logic [4:0] rb, input logic [2:0] cc);
    return {op, rd, ra, 1'b0, rb, cc, 8'h00};
  endfunction

  function automatic logic [31:0] mki(input logic [4:0] op, input logic [4:0] rd, input logic [4:0] ra,
                                      input logic [15:0] imm);
    return {op, rd, ra, 1'b1, imm};
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [31:0] w;
    int r;
    w = $urandom;
    r = $urandom_range(0, 15);
    w[31:27] = (r < 11) ? 5'(r) : 5'($urandom_range(11, 31));
    w[26:22] = 5'($urandom_range(0, 7));
    w[21:17] = 5'($urandom_range(0, 7));
    if (!w[16]) w[15:11] = 5'($urandom_range(0, 7));
    return w;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    if (wb_valid) rf[wb_rd] = wb_dat;
  endtask

  task automatic wb(input logic [4:0] r, input logic [31:0] d);
    wb_valid = 1; wb_rd = r; wb_dat = d;
    tick();
    wb_valid = 0;
  endtask

  initial begin
    int stall_cnt;
    int max_stall;
    rst = 1; in_valid = 0; in_instr = 0; ex_ready = 1; wb_valid = 0; wb_rd = 0; wb_dat = 0;
    for (int i = 0; i < 32; i++) rf[i] = $urandom;
    rf[0] = 32'hDEAD_BEEF; rf[1] = 32'd5; rf[2] = 32'd7;

    // reset state
    @(posedge clk); #1;
    check("reset_ex_valid", {63'd0, ex_valid}, 64'd0);
    check("reset_data_a", {32'd0, ex_data_a}, 64'd0);
    tick();
    rst = 0;

    // ADD r3,r1,r2
    in_instr = mk(ADD, 5'd3, 5'd1, 5'd2, 3'd2); in_valid = 1;
    tick();
    in_valid = 0;
    check("add_valid", {63'd0, ex_valid}, 64'd1);
    check("add_bundle", {ex_opcode, ex_cc, ex_rd, ex_wen}, {50'd0, ADD, 3'd2, 5'd3, 1'b1});
    check("add_data", {ex_data_a, ex_data_b}, {32'd5, 32'd7});

    // RAW hazard on r3
    in_instr = mk(SUB, 5'd4, 5'd3, 5'd1, 3'd0); in_valid = 1;
    #1 check("raw_stall", {63'd0, in_ready}, 64'd0);
    tick(); tick();
    wb_valid = 1; wb_rd = 5'd3; wb_dat = 32'd100;
    #1 check("raw_no_bypass", {63'd0, in_ready}, 64'd0);
    tick();
    wb_valid = 0;
    check("raw_lifted", {63'd0, in_ready}, 64'd1);
    tick();
    in_valid = 0;
    check("sub_bundle", {ex_opcode, ex_rd, ex_data_a, ex_data_b}, {SUB, 5'd4, 32'd100, 32'd5});
    wb(5'd4, 32'd44);

    // immediate form, then MOV not stalled by a pending rb field
    in_instr = mki(SRA, 5'd2, 5'd1, 16'hFFF0); in_valid = 1;
    tick();
    check("sra_imm", {ex_opcode, ex_cc, ex_data_b}, {SRA, 3'd0, 32'hFFFF_FFF0});
    in_instr = mk(MOV, 5'd5, 5'd1, 5'd2, 3'd0);
    #1 check("mov_no_stall", {63'd0, in_ready}, 64'd1);
    tick();
    in_valid = 0;
    check("mov_bundle", {ex_opcode, ex_rd, ex_data_a}, {MOV, 5'd5, 32'd5});
    wb(5'd2, 32'd22);
    wb(5'd5, 32'd55);

    // backpressure
    ex_ready = 0;
    in_instr = mk(ADD, 5'd6, 5'd1, 5'd1, 3'd1); in_valid = 1;
    tick();
    in_instr = mk(XOR, 5'd7, 5'd1, 5'd1, 3'd3);
    for (int i = 0; i < 3; i++) begin
      check("hold_ready", {63'd0, in_ready}, 64'd0);
      check("hold_bundle", {ex_valid, ex_opcode, ex_rd, ex_data_a}, {1'b1, ADD, 5'd6, 32'd5});
      tick();
    end
    ex_ready = 1;
    #1 check("release_ready", {63'd0, in_ready}, 64'd1);
    tick();
    in_valid = 0;
    check("xor_loaded", {ex_valid, ex_opcode, ex_rd}, {1'b1, XOR, 5'd7});
    tick();
    wb(5'd6, 32'd66);
    wb(5'd7, 32'd77);

    // undefined opcode and r0 destination / source
    in_instr = mk(5'h1F, 5'd8, 5'd1, 5'd1, 3'd0); in_valid = 1;
    tick();
    in_valid = 0;
    check("illegal_pulse", {ex_valid, illegal}, {1'b0, 1'b1});
    tick();
    check("illegal_clear", {63'd0, illegal}, 64'd0);
    in_instr = mk(ADD, 5'd9, 5'd8, 5'd8, 3'd0); in_valid = 1;
    #1 check("illegal_no_pend", {63'd0, in_ready}, 64'd1);
    tick();
    in_instr = mk(ADD, 5'd0, 5'd1, 5'd2, 3'd0);
    tick();
    check("r0_dest", {ex_rd, ex_wen}, {5'd0, 1'b0});
    in_instr = mk(ADD, 5'd10, 5'd0, 5'd0, 3'd0);
    #1 check("r0_not_pending", {63'd0, in_ready}, 64'd1);
    tick();
    in_valid = 0;
    check("r0_reads_zero", {ex_data_a, ex_data_b}, 64'd0);
    wb(5'd9, 32'd99);
    wb(5'd10, 32'd1010);

    // reset while stalled
    ex_ready = 0;
    in_instr = mk(ADD, 5'd3, 5'd1, 5'd2, 3'd0); in_valid = 1;
    tick();
    in_instr = mk(SUB, 5'd4, 5'd3, 5'd1, 3'd0);
    tick();
    check("pre_rst_stall", {ex_valid, in_ready}, {1'b1, 1'b0});
    #2 rst = 1;
    #1 check("async_rst", {ex_valid, illegal, ex_wen, ex_data_a}, 35'd0);
    check("rst_unstall", {63'd0, in_ready}, 64'd1);
    tick();
    rst = 0; ex_ready = 1;
    #1 check("post_rst_ready", {63'd0, in_ready}, 64'd1);
    tick();
    in_valid = 0;
    check("post_rst_issue", {ex_valid, ex_opcode, ex_data_a}, {1'b1, SUB, 32'd100});
    tick();

    // randomized traffic
    stall_cnt = 0; max_stall = 0;
    for (int c = 0; c < 4000; c++) begin
      ex_ready = ($urandom_range(0, 3) != 0);
      if (wbq.size() > 0 && $urandom_range(0, 2) == 0) begin
        wb_valid = 1; wb_rd = wbq.pop_front(); wb_dat = $urandom;
      end else begin
        wb_valid = 0;
      end
      if (!in_valid || hs_in) begin
        stall_cnt = 0;
        if ($urandom_range(0, 3) != 0) begin
          in_valid = 1; in_instr = rand_instr();
        end else begin
          in_valid = 0;
        end
      end else begin
        stall_cnt++;
        if (stall_cnt > max_stall) max_stall = stall_cnt;
        if (stall_cnt > 300) break;
      end
      tick();
    end
    in_valid = 0; wb_valid = 0;
    check("stall_watchdog", {63'd0, (max_stall > 300)}, 64'd0);
    tick(); tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
